// File: rtl/char_write_scheduler_pkg.sv
// rtl/char_write_scheduler_pkg.sv - shared geometry defaults and state encodings
package char_write_scheduler_pkg;

  localparam int          ROWS_DEF       = 24;
  localparam int          COLS_DEF       = 80;
  localparam int          ADDR_BITS_DEF  = 11;
  localparam int          COUNT_BITS_DEF = 12;
  localparam logic [7:0]  BLANK_CHAR_DEF = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_SFILL   = 2'd2,
    ST_SCOMMIT = 2'd3
  } state_t;

  // Owner of the most recent buffer-port grant.
  typedef enum logic {
    RR_FILL = 1'b0,
    RR_WR   = 1'b1
  } rr_t;

endpackage

// File: rtl/char_write_scheduler_wrap_counter.sv
// rtl/char_write_scheduler_wrap_counter.sv - loadable counter stepping by STEP modulo SIZE
// Ports: clk/reset (async, active-high), load + load_value (load wins over inc),
//        inc (advance by STEP, wrapping at SIZE), value (registered count).
module char_write_scheduler_wrap_counter #(
  parameter int WIDTH = 11,
  parameter int SIZE  = 1920,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH:0] SIZE_W = SIZE[WIDTH:0];
  localparam logic [WIDTH:0] STEP_W = STEP[WIDTH:0];

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrapped;

  // value is always < SIZE, so one conditional subtract is enough.
  always_comb begin
    sum     = {1'b0, value} + STEP_W;
    wrapped = sum[WIDTH-1:0];
    if (sum >= SIZE_W) begin
      wrapped = WIDTH'(sum - SIZE_W);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= wrapped;
    end
  end

endmodule

// File: rtl/char_write_scheduler.sv
// rtl/char_write_scheduler.sv - arbitrates the char_buffer write port and owns first_char
// Ports: clk/reset (async, active-high);
//        wr_*      single-character write handshake from command_handler;
//        fill_*    bulk fill request, scroll_* scroll-one-row request (ready only when idle);
//        buf_*     registered char_buffer write port;
//        first_char/first_char_wen registered scroll origin and its change pulse;
//        busy (engine active), done (one-cycle completion pulse).
module char_write_scheduler
  import char_write_scheduler_pkg::*;
#(
  parameter int         ROWS       = ROWS_DEF,
  parameter int         COLS       = COLS_DEF,
  parameter int         ADDR_BITS  = ADDR_BITS_DEF,
  parameter int         COUNT_BITS = COUNT_BITS_DEF,
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [7:0]            wr_char,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [ADDR_BITS-1:0]  fill_addr,
  input  logic [COUNT_BITS-1:0] fill_count,
  input  logic [7:0]            fill_char,
  input  logic                  scroll_valid,
  output logic                  scroll_ready,
  output logic [ADDR_BITS-1:0]  buf_addr,
  output logic [7:0]            buf_char,
  output logic                  buf_wen,
  output logic [ADDR_BITS-1:0]  first_char,
  output logic                  first_char_wen,
  output logic                  busy,
  output logic                  done
);

  localparam int                    SIZE   = ROWS * COLS;
  localparam logic [COUNT_BITS-1:0] SIZE_C = SIZE[COUNT_BITS-1:0];
  localparam logic [COUNT_BITS-1:0] COLS_C = COLS[COUNT_BITS-1:0];

  state_t                  state, state_nxt;
  rr_t                     rr;
  logic [COUNT_BITS-1:0]   remaining;
  logic [7:0]              data;
  logic [ADDR_BITS-1:0]    ptr;

  logic                    wr_grant;
  logic                    beat;
  logic                    fill_acc;
  logic                    scroll_acc;
  logic                    fill_done;
  logic                    commit;

  assign fill_ready   = (state == ST_IDLE);
  assign scroll_ready = fill_ready;
  assign busy         = (state != ST_IDLE);

  // Decoded from registers only, so a requester cannot see combinational feedback.
  always_comb begin
    wr_ready = 1'b1;
    if (state == ST_FILL || state == ST_SFILL) begin
      wr_ready = (rr == RR_FILL);
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_grant   = wr_valid && wr_ready;
    scroll_acc = 1'b0;
    fill_acc   = 1'b0;
    beat       = 1'b0;
    fill_done  = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scroll_valid) begin
          scroll_acc = 1'b1;
          state_nxt  = ST_SFILL;
        end else if (fill_valid) begin
          fill_acc  = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        // A zero-length fill lands here with nothing to write.
        if (remaining == '0) begin
          fill_done = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!wr_grant) begin
          beat = 1'b1;
          if (remaining == COUNT_BITS'(1)) begin
            fill_done = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_SFILL: begin
        if (!wr_grant && remaining != '0) begin
          beat = 1'b1;
          if (remaining == COUNT_BITS'(1)) begin
            state_nxt = ST_SCOMMIT;
          end
        end
      end
      ST_SCOMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      rr             <= RR_FILL;
      remaining      <= '0;
      data           <= '0;
      buf_addr       <= '0;
      buf_char       <= '0;
      buf_wen        <= 1'b0;
      first_char_wen <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      buf_wen        <= wr_grant || beat;
      first_char_wen <= commit;
      done           <= fill_done || commit;
      if (wr_grant) begin
        buf_addr <= wr_addr;
        buf_char <= wr_char;
        rr       <= RR_WR;
      end else if (beat) begin
        buf_addr <= ptr;
        buf_char <= data;
        rr       <= RR_FILL;
      end
      if (fill_acc) begin
        remaining <= (fill_count > SIZE_C) ? SIZE_C : fill_count;
        data      <= fill_char;
      end else if (scroll_acc) begin
        remaining <= COLS_C;
        data      <= BLANK_CHAR;
      end else if (beat) begin
        remaining <= remaining - COUNT_BITS'(1);
      end
    end
  end

  // Fill pointer: starts at fill_addr, or at the row being recycled for a scroll.
  char_write_scheduler_wrap_counter #(
    .WIDTH (ADDR_BITS),
    .SIZE  (SIZE),
    .STEP  (1)
  ) u_ptr (
    .clk        (clk),
    .reset      (reset),
    .load       (fill_acc || scroll_acc),
    .load_value (scroll_acc ? first_char : fill_addr),
    .inc        (beat),
    .value      (ptr)
  );

  // Scroll origin advances by one row per committed scroll.
  char_write_scheduler_wrap_counter #(
    .WIDTH (ADDR_BITS),
    .SIZE  (SIZE),
    .STEP  (COLS)
  ) u_first_char (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_value ('0),
    .inc        (commit),
    .value      (first_char)
  );

endmodule
